// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared types and constants for the MEM-stage SRAM interface.
package arm_mem_pkg;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} mem_state_t;
    localparam logic [31:0] MEM_BASE_DEFAULT = 32'd1024;
    localparam int SRAM_DW = 16;
endpackage

// File: rtl/sram_wait_timer.sv
// sram_wait_timer: per-phase wait-state counter; expire marks the last cycle of a half-access.
module sram_wait_timer #(
    parameter int WAIT_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expire
);
    logic [3:0] count;
    always_ff @(posedge clk)
        count <= (rst || clear) ? 4'd0 : count + 4'd1;
    assign expire = count == 4'(WAIT_CYCLES - 1);
endmodule

// File: rtl/mem_stage_sram.sv
// mem_stage_sram: MEM stage splitting each 32-bit load/store into two 16-bit SRAM accesses.
// Optional `MEM_STALL_CNT_EN adds a saturating stall-cycle counter output.
module mem_stage_sram import arm_mem_pkg::*; #(
    parameter logic [31:0] MEM_BASE    = MEM_BASE_DEFAULT,
    parameter int          WAIT_CYCLES = 3,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
`ifdef MEM_STALL_CNT_EN
    output logic [31:0]        stall_cycles,
`endif
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        rm_value,
    output logic [31:0]        rd_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_wdata,
    input  logic [SRAM_DW-1:0] sram_rdata,
    output logic               sram_we_n,
    output logic               sram_oe_n
);
    mem_state_t         state;
    logic               write_q;
    logic [SRAM_AW-2:0] word_q;
    logic [31:0]        data_q;
    logic [31:0]        offset;
    logic               req, busy, expire;
    logic               unused_offset;

    assign req    = mem_r_en | mem_w_en;
    assign offset = alu_result - MEM_BASE;
    assign busy   = state == LO || state == HI;
    assign ready  = state == DONE || (state == IDLE && !req);
    // only the word index within SRAM reach is kept; byte lane and high bits are dropped
    assign unused_offset = ^{offset[31:SRAM_AW+1], offset[1:0]};

    sram_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!busy || expire),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            write_q <= 1'b0;
            word_q  <= '0;
            data_q  <= '0;
            rd_data <= '0;
        end else begin
            state <= state == IDLE ? (req ? LO : IDLE) :
                     state == DONE ? IDLE :
                     !expire       ? state :
                     state == LO   ? HI : DONE;
            if (state == IDLE && req) begin
                write_q <= mem_w_en;
                word_q  <= offset[SRAM_AW:2];
                data_q  <= rm_value;
            end
            if (state == LO && expire && !write_q)
                rd_data[15:0] <= sram_rdata;
            if (state == HI && expire && !write_q)
                rd_data[31:16] <= sram_rdata;
        end
    end

    assign sram_addr  = {word_q, state == HI};
    assign sram_wdata = state == HI ? data_q[31:16] : data_q[15:0];
    assign sram_we_n  = !(busy && write_q);
    assign sram_oe_n  = !(busy && !write_q);

`ifdef MEM_STALL_CNT_EN
    always_ff @(posedge clk)
        stall_cycles <= rst ? 32'd0 :
                        (!ready && stall_cycles != 32'hFFFF_FFFF) ? stall_cycles + 32'd1 : stall_cycles;
`endif
endmodule

// File: tb/tb_mem_stage_sram.sv
// tb_mem_stage_sram: table-driven and randomized checks of mem_stage_sram against a word-level memory model.
module tb_mem_stage_sram;
    localparam int          WAIT = 3;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk, rst, mem_r_en, mem_w_en;
    logic [31:0] alu_result, rm_value, rd_data;
    logic        ready, sram_we_n, sram_oe_n;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata, sram_rdata;
`ifdef MEM_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;
    int total_stalls;
    logic [31:0] exp_rd;
    logic [15:0] sram_mem [logic [17:0]];
    logic [31:0] ref_mem [logic [16:0]];

    mem_stage_sram #(.MEM_BASE(BASE), .WAIT_CYCLES(WAIT), .SRAM_AW(18)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef MEM_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .alu_result (alu_result),
        .rm_value   (rm_value),
        .rd_data    (rd_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // SRAM device: unwritten locations hold a pattern derived from their address
    function automatic logic [15:0] init_half(input logic [17:0] ha);
        return ha[15:0] ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] sram_read(input logic [17:0] ha);
        return sram_mem.exists(ha) ? sram_mem[ha] : init_half(ha);
    endfunction

    assign sram_rdata = sram_oe_n ? 16'h0 : sram_read(sram_addr);

    always @(posedge clk)
        if (!sram_we_n) sram_mem[sram_addr] = sram_wdata;

    function automatic logic [16:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return 17'((off / 4) % (1 << 17));
    endfunction

    function automatic logic [31:0] ref_load(input logic [16:0] idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : {init_half({idx, 1'b1}), init_half({idx, 1'b0})};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request starting in IDLE; returns sampled in the DONE cycle.
    task automatic run_req(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        int n;
        logic [16:0] idx;
        logic [35:0] act, exp;
        mem_w_en = w; mem_r_en = r; alu_result = a; rm_value = d;
        #1;
        idx = word_idx(a);
        n = 0;
        while (!ready && n < 40) begin
            if (n == 0) begin
                check("idle strobes", {sram_we_n, sram_oe_n}, 2'b11);
            end else if (n <= 2 * WAIT) begin
                act = {sram_addr, w ? sram_wdata : 16'h0, sram_we_n, sram_oe_n};
                exp = {idx, 1'(n > WAIT), w ? (n > WAIT ? d[31:16] : d[15:0]) : 16'h0, !w, w};
                check("sram access", act, exp);
            end
            n++;
            tick();
        end
        check("stall cycles", n, 2 * WAIT + 1);
        check("done strobes", {sram_we_n, sram_oe_n}, 2'b11);
        if (w) ref_mem[idx] = d;
        else exp_rd = ref_load(idx);
        check("rd_data", rd_data, exp_rd);
        total_stalls += n;
    endtask

    task automatic idle();
        mem_w_en = 0; mem_r_en = 0;
        #1;
        check("idle ready", {ready, sram_we_n, sram_oe_n}, 3'b111);
        tick();
    endtask

    typedef struct {
        bit          w;
        bit          r;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1, 0, 32'd1028, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{0, 1, 32'd1028, 32'h0,         32'hDEAD_BEEF};
        vecs[2] = '{1, 0, 32'd2048, 32'hCAFE_F00D, 32'hDEAD_BEEF};
        vecs[3] = '{1, 1, 32'd1028, 32'h1111_2222, 32'hDEAD_BEEF};
        vecs[4] = '{0, 1, 32'd1028, 32'h0,         32'h1111_2222};
        vecs[5] = '{0, 1, 32'd2048, 32'h0,         32'hCAFE_F00D};
        vecs[6] = '{1, 0, 32'd1000, 32'h0BAD_C0DE, 32'hCAFE_F00D};
        vecs[7] = '{0, 1, 32'd1000, 32'h0,         32'h0BAD_C0DE};
        vecs[8] = '{0, 1, 32'd1030, 32'h0,         32'h1111_2222};

        rst = 1; mem_r_en = 1; mem_w_en = 0; alu_result = 32'd1028; rm_value = 0;
        exp_rd = 0; total_stalls = 0;
        tick();
        check("reset ready", ready, 0);
        check("reset rd_data", rd_data, 0);
        check("reset strobes", {sram_we_n, sram_oe_n}, 2'b11);
        check("reset addr", sram_addr, 0);
        check("reset wdata", sram_wdata, 0);
        rst = 0; mem_r_en = 0;
        tick();

        foreach (vecs[i]) begin
            run_req(vecs[i].w, vecs[i].r, vecs[i].addr, vecs[i].data);
            check("table rd_data", rd_data, vecs[i].exp_rd);
            tick();
            idle();
        end

        total_stalls = 0;
        run_req(0, 1, 32'd1028, 32'h0);
        tick();
        run_req(1, 0, 32'd3072, 32'h1357_9BDF);
        check("back-to-back stalls", total_stalls, 2 * (2 * WAIT + 1));
        tick();

        for (int i = 0; i < 5; i++) idle();

        for (int i = 0; i < 24; i++) begin
            bit w;
            w = 1'($urandom_range(0, 1));
            run_req(w, !w || 1'($urandom_range(0, 1)), BASE + 4 * $urandom_range(0, 31), $urandom);
            tick();
            if ($urandom_range(0, 1) == 1) idle();
        end

        mem_w_en = 1; mem_r_en = 0; alu_result = 32'd4096; rm_value = 32'hA5A5_5A5A;
        for (int i = 0; i < 4; i++) tick();
        check("abort in HI", {sram_we_n, sram_addr[0]}, 2'b01);
        rst = 1; mem_w_en = 0;
        tick();
        check("abort strobes", {sram_we_n, sram_oe_n}, 2'b11);
        check("abort ready", ready, 1);
        check("abort rd_data", rd_data, 0);
`ifdef MEM_STALL_CNT_EN
        check("abort stall count", stall_cycles, 0);
`endif
        rst = 0;
        tick();
        check("post-abort idle", {ready, sram_we_n, sram_oe_n}, 3'b111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
